// File: rtl/rhythm_lane_engine.sv
// rhythm_lane_engine
//   Game core for the rhythm game: LANES note columns of ROWS cells that scroll
//   towards a judge line, with tick generation, random note spawning, two-level
//   hit judgement, score/combo/HP bookkeeping, high-score retention and the
//   IDLE/PLAY/OVER game-state FSM.
//
// Ports
//   i_Clk        system clock
//   i_Rst        synchronous active-high reset
//   i_Pulse      one-cycle press pulses, bit k = lane k
//   i_Rand       free-running random value (bit 7 = spawn enable, low bits = lane)
//   i_Speed      scroll speed select (period = TICK_BASE >> i_Speed)
//   i_Start      start switch (level)
//   o_Map        field, bit [k*ROWS+r] = lane k, row r (row ROWS-1 is the judge line)
//   o_Score      current score (saturating)
//   o_Combo      current combo (saturating)
//   o_High_Score best score since reset
//   o_HP         HP thermometer, bits [hp-1:0] set
//   o_State      00 IDLE, 01 PLAY, 10 OVER
//   o_Judge      00 none, 01 perfect, 10 good, 11 miss
//   o_Judge_Vld  one-cycle strobe accompanying o_Judge
module rhythm_lane_engine #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned TICK_BASE = 12_500_000,
  parameter int unsigned HP_MAX    = 10,
  parameter int unsigned SCORE_W   = 16,
  parameter int unsigned COMBO_W   = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [LANES-1:0]      i_Pulse,
  input  logic [7:0]            i_Rand,
  input  logic [1:0]            i_Speed,
  input  logic                  i_Start,
  output logic [LANES*ROWS-1:0] o_Map,
  output logic [SCORE_W-1:0]    o_Score,
  output logic [COMBO_W-1:0]    o_Combo,
  output logic [SCORE_W-1:0]    o_High_Score,
  output logic [HP_MAX-1:0]     o_HP,
  output logic [1:0]            o_State,
  output logic [1:0]            o_Judge,
  output logic                  o_Judge_Vld
);

  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned CNT_W  = $clog2(TICK_BASE + 1);
  localparam int unsigned HP_W   = $clog2(HP_MAX + 1);
  localparam int unsigned HIT_W  = $clog2(LANES + 1);
  localparam int unsigned PTS_W  = $clog2(LANES * 10 + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  state_t                        state_q;
  logic [LANES-1:0][ROWS-1:0]    map_q;
  logic [SCORE_W-1:0]            score_q, high_q;
  logic [COMBO_W-1:0]            combo_q;
  logic [HP_W-1:0]               hp_q;
  logic [CNT_W-1:0]              cnt_q, period_q;
  logic                          start_sync, start_prev;
  logic [1:0]                    judge_q;
  logic                          judge_vld_q;

  logic                          start_rise, tick;
  logic [CNT_W-1:0]              speed_period;
  logic [LANES-1:0]              pulse, perf, good, empty_press, miss;
  logic [LANES-1:0][ROWS-1:0]    map_hit, map_next;
  logic [LANE_W-1:0]             spawn_lane;
  logic [HIT_W-1:0]              n_hits, n_miss;
  logic [PTS_W-1:0]              pts;
  logic [SCORE_W:0]              score_sum;
  logic [COMBO_W:0]              combo_sum;
  logic [SCORE_W-1:0]            score_next;
  logic [COMBO_W-1:0]            combo_next;
  logic [HP_W-1:0]               hp_next;
  logic                          unused_rand;

  assign unused_rand  = &{1'b0, i_Rand[6:LANE_W]};
  assign start_rise   = start_sync & ~start_prev;
  assign speed_period = CNT_W'(TICK_BASE >> i_Speed);
  assign tick         = (state_q == ST_PLAY) && (cnt_q == period_q - CNT_W'(1));
  assign spawn_lane   = i_Rand[LANE_W-1:0];

  // Hits are judged against the pre-shift map; notes they clear are removed
  // before the scroll, so a note hit on a tick cycle can never also miss.
  always_comb begin
    pulse       = (state_q == ST_PLAY) ? i_Pulse : '0;
    perf        = '0;
    good        = '0;
    empty_press = '0;
    miss        = '0;
    map_hit     = map_q;
    n_hits      = '0;
    n_miss      = '0;
    pts         = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (pulse[k]) begin
        if (map_q[k][ROWS-1]) begin
          perf[k]             = 1'b1;
          map_hit[k][ROWS-1]  = 1'b0;
        end else if (map_q[k][ROWS-2]) begin
          good[k]             = 1'b1;
          map_hit[k][ROWS-2]  = 1'b0;
        end else begin
          empty_press[k]      = 1'b1;
        end
      end
    end
    map_next = map_hit;
    if (tick) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        miss[k]     = map_hit[k][ROWS-1];
        map_next[k] = {map_hit[k][ROWS-2:0], 1'b0};
      end
      if (i_Rand[7] && !map_hit[spawn_lane][0] && !map_hit[spawn_lane][1])
        map_next[spawn_lane][0] = 1'b1;
    end
    for (int unsigned k = 0; k < LANES; k++) begin
      n_hits = n_hits + HIT_W'(perf[k] | good[k]);
      n_miss = n_miss + HIT_W'(miss[k]);
      if (perf[k])      pts = pts + PTS_W'(10);
      else if (good[k]) pts = pts + PTS_W'(5);
    end

    score_sum  = {1'b0, score_q} + (SCORE_W+1)'(pts);
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    combo_sum  = {1'b0, combo_q} + (COMBO_W+1)'(n_hits);
    combo_next = combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0];
    if ((|miss) || (|empty_press))
      combo_next = '0;
    if ({{HIT_W{1'b0}}, hp_q} > {{HP_W{1'b0}}, n_miss})
      hp_next = hp_q - HP_W'(n_miss);
    else
      hp_next = '0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      map_q       <= '0;
      score_q     <= '0;
      high_q      <= '0;
      combo_q     <= '0;
      hp_q        <= HP_W'(HP_MAX);
      cnt_q       <= '0;
      period_q    <= CNT_W'(TICK_BASE);
      start_sync  <= 1'b0;
      start_prev  <= 1'b0;
      judge_q     <= 2'b00;
      judge_vld_q <= 1'b0;
    end else begin
      start_sync  <= i_Start;
      start_prev  <= start_sync;
      judge_q     <= 2'b00;
      judge_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            state_q  <= ST_PLAY;
            map_q    <= '0;
            score_q  <= '0;
            combo_q  <= '0;
            hp_q     <= HP_W'(HP_MAX);
            cnt_q    <= '0;
            period_q <= speed_period;
          end
        end
        ST_PLAY: begin
          map_q   <= map_next;
          score_q <= score_next;
          combo_q <= combo_next;
          hp_q    <= hp_next;
          if (tick) begin
            cnt_q    <= '0;
            period_q <= speed_period;
          end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
          end
          if (|miss) begin
            judge_q     <= 2'b11;
            judge_vld_q <= 1'b1;
          end else if (|perf) begin
            judge_q     <= 2'b01;
            judge_vld_q <= 1'b1;
          end else if (|good) begin
            judge_q     <= 2'b10;
            judge_vld_q <= 1'b1;
          end
          if (hp_q == '0) begin
            state_q <= ST_OVER;
            if (score_q > high_q)
              high_q <= score_q;
          end
        end
        ST_OVER: begin
          if (!i_Start)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_HP = '0;
    for (int unsigned i = 0; i < HP_MAX; i++)
      o_HP[i] = (HP_W'(i) < hp_q);
  end

  assign o_Map        = map_q;
  assign o_Score      = score_q;
  assign o_Combo      = combo_q;
  assign o_High_Score = high_q;
  assign o_State      = state_q;
  assign o_Judge      = judge_q;
  assign o_Judge_Vld  = judge_vld_q;

endmodule

// File: tb/tb_rhythm_lane_engine.sv
module tb_rhythm_lane_engine;

  localparam int unsigned LANES     = 4;
  localparam int unsigned ROWS      = 8;
  localparam int unsigned TICK_BASE = 16;
  localparam int unsigned HP_MAX    = 10;
  localparam int unsigned SCORE_W   = 16;
  localparam int unsigned COMBO_W   = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [LANES-1:0]      pulse;
  logic [7:0]            rnd;
  logic [1:0]            speed;
  logic                  start;
  logic [LANES*ROWS-1:0] map;
  logic [SCORE_W-1:0]    score;
  logic [COMBO_W-1:0]    combo;
  logic [SCORE_W-1:0]    high;
  logic [HP_MAX-1:0]     hp;
  logic [1:0]            state;
  logic [1:0]            judge;
  logic                  judge_vld;

  always #5 clk = ~clk;

  rhythm_lane_engine #(
    .LANES(LANES), .ROWS(ROWS), .TICK_BASE(TICK_BASE),
    .HP_MAX(HP_MAX), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Pulse(pulse), .i_Rand(rnd), .i_Speed(speed),
    .i_Start(start), .o_Map(map), .o_Score(score), .o_Combo(combo),
    .o_High_Score(high), .o_HP(hp), .o_State(state), .o_Judge(judge),
    .o_Judge_Vld(judge_vld)
  );

  typedef struct {
    logic [3:0]  pulse;
    logic [7:0]  rnd;
    logic [31:0] map;
    int          score;
    int          combo;
    int          hp;
    logic [1:0]  judge;
    logic        vld;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [3:0] p, input logic [7:0] r,
                              input logic [31:0] m, input int s, input int c,
                              input int h, input logic [1:0] j, input logic v);
    vec_t x;
    x.pulse = p; x.rnd = r; x.map = m; x.score = s; x.combo = c;
    x.hp = h; x.judge = j; x.vld = v;
    return x;
  endfunction

  function automatic logic [31:0] therm(input int h);
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < h; i++) t[i] = 1'b1;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 32'h0);
    chk({tag, "_map"},   32'(map),   32'h0);
    chk({tag, "_score"}, 32'(score), 32'h0);
    chk({tag, "_combo"}, 32'(combo), 32'h0);
    chk({tag, "_high"},  32'(high),  32'h0);
    chk({tag, "_hp"},    32'(hp),    32'h3FF);
    chk({tag, "_judge"}, 32'(judge), 32'h0);
    chk({tag, "_vld"},   32'(judge_vld), 32'h0);
  endtask

  // Feeds one note per tick, rotating lanes, with no presses until OVER.
  task automatic run_until_over(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      rnd = 8'h80 | 8'(((c / 2) % 4));
      step();
      if (state == 2'b10) begin
        ok = 1'b1;
        break;
      end
    end
    rnd = 8'h00;
  endtask

  initial begin
    bit ok;

    // Row j is applied for the (j+1)-th cycle after the first spawn.
    // Ticks (period 2) land on odd rows.
    //                pulse  rnd    map           sc cb hp judge vld
    vecs.push_back(mk(4'h0, 8'h00, 32'h00010000,  0, 0, 10, 2'b00, 1'b0)); // 0
    vecs.push_back(mk(4'h0, 8'h00, 32'h00020000,  0, 0, 10, 2'b00, 1'b0)); // 1
    vecs.push_back(mk(4'h0, 8'h00, 32'h00020000,  0, 0, 10, 2'b00, 1'b0)); // 2
    vecs.push_back(mk(4'h0, 8'h00, 32'h00040000,  0, 0, 10, 2'b00, 1'b0)); // 3
    vecs.push_back(mk(4'h0, 8'h00, 32'h00040000,  0, 0, 10, 2'b00, 1'b0)); // 4
    vecs.push_back(mk(4'h0, 8'h82, 32'h00090000,  0, 0, 10, 2'b00, 1'b0)); // 5
    vecs.push_back(mk(4'h0, 8'h00, 32'h00090000,  0, 0, 10, 2'b00, 1'b0)); // 6
    vecs.push_back(mk(4'h0, 8'h00, 32'h00120000,  0, 0, 10, 2'b00, 1'b0)); // 7
    vecs.push_back(mk(4'h0, 8'h00, 32'h00120000,  0, 0, 10, 2'b00, 1'b0)); // 8
    vecs.push_back(mk(4'h0, 8'h81, 32'h00240100,  0, 0, 10, 2'b00, 1'b0)); // 9
    vecs.push_back(mk(4'h0, 8'h00, 32'h00240100,  0, 0, 10, 2'b00, 1'b0)); // 10
    vecs.push_back(mk(4'h0, 8'h80, 32'h00480201,  0, 0, 10, 2'b00, 1'b0)); // 11
    vecs.push_back(mk(4'h0, 8'h00, 32'h00480201,  0, 0, 10, 2'b00, 1'b0)); // 12
    vecs.push_back(mk(4'h0, 8'h00, 32'h00900402,  0, 0, 10, 2'b00, 1'b0)); // 13 note at bit 23
    vecs.push_back(mk(4'h0, 8'h00, 32'h00900402,  0, 0, 10, 2'b00, 1'b0)); // 14
    vecs.push_back(mk(4'h0, 8'h83, 32'h01200804,  0, 0,  9, 2'b11, 1'b1)); // 15 miss
    vecs.push_back(mk(4'h0, 8'h00, 32'h01200804,  0, 0,  9, 2'b00, 1'b0)); // 16
    vecs.push_back(mk(4'h0, 8'h81, 32'h02401108,  0, 0,  9, 2'b00, 1'b0)); // 17
    vecs.push_back(mk(4'h0, 8'h00, 32'h02401108,  0, 0,  9, 2'b00, 1'b0)); // 18
    vecs.push_back(mk(4'h0, 8'h80, 32'h04802211,  0, 0,  9, 2'b00, 1'b0)); // 19
    vecs.push_back(mk(4'h4, 8'h00, 32'h04002211, 10, 1,  9, 2'b01, 1'b1)); // 20 perfect
    vecs.push_back(mk(4'h0, 8'h83, 32'h09004422, 10, 1,  9, 2'b00, 1'b0)); // 21
    vecs.push_back(mk(4'h2, 8'h00, 32'h09000422, 15, 2,  9, 2'b10, 1'b1)); // 22 good
    vecs.push_back(mk(4'h0, 8'h00, 32'h12000844, 15, 2,  9, 2'b00, 1'b0)); // 23
    vecs.push_back(mk(4'h0, 8'h00, 32'h12000844, 15, 2,  9, 2'b00, 1'b0)); // 24
    vecs.push_back(mk(4'h0, 8'h00, 32'h24001088, 15, 2,  9, 2'b00, 1'b0)); // 25
    vecs.push_back(mk(4'h0, 8'h00, 32'h24001088, 15, 2,  9, 2'b00, 1'b0)); // 26
    vecs.push_back(mk(4'h1, 8'h00, 32'h48002010, 25, 3,  9, 2'b01, 1'b1)); // 27 press on tick
    vecs.push_back(mk(4'h4, 8'h00, 32'h48002010, 25, 0,  9, 2'b00, 1'b0)); // 28 empty press
    vecs.push_back(mk(4'h0, 8'h00, 32'h90004020, 25, 0,  9, 2'b00, 1'b0)); // 29
    vecs.push_back(mk(4'hA, 8'h00, 32'h10000020, 40, 2,  9, 2'b01, 1'b1)); // 30 perfect+good
    vecs.push_back(mk(4'h0, 8'h00, 32'h20000040, 40, 2,  9, 2'b00, 1'b0)); // 31
    vecs.push_back(mk(4'h0, 8'h00, 32'h20000040, 40, 2,  9, 2'b00, 1'b0)); // 32
    vecs.push_back(mk(4'h0, 8'h00, 32'h40000080, 40, 2,  9, 2'b00, 1'b0)); // 33
    vecs.push_back(mk(4'h0, 8'h00, 32'h40000080, 40, 2,  9, 2'b00, 1'b0)); // 34
    vecs.push_back(mk(4'h8, 8'h00, 32'h00000000, 45, 0,  8, 2'b11, 1'b1)); // 35 good+miss
    vecs.push_back(mk(4'h0, 8'h00, 32'h00000000, 45, 0,  8, 2'b00, 1'b0)); // 36

    rst = 1'b1; pulse = '0; rnd = 8'h00; speed = 2'd0; start = 1'b0;
    step();
    chk_idle_reset("reset");

    rst = 1'b0; start = 1'b1; rnd = 8'h82;
    step();
    chk("start_1cyc_state", 32'(state), 32'h0);
    step();
    chk("start_2cyc_state", 32'(state), 32'h1);
    chk("entry_map", 32'(map), 32'h0);
    chk("entry_hp",  32'(hp),  32'h3FF);

    // Speed raised mid-period: the first period must still be the full 16 cycles.
    for (int i = 1; i <= 15; i++) begin
      if (i == 8) speed = 2'd3;
      step();
    end
    chk("no_tick_before_16", 32'(map), 32'h0);
    step();
    chk("first_tick_spawn", 32'(map), 32'h00010000);

    foreach (vecs[j]) begin
      pulse = vecs[j].pulse;
      rnd   = vecs[j].rnd;
      step();
      chk($sformatf("v%0d_map", j),   32'(map),       vecs[j].map);
      chk($sformatf("v%0d_score", j), 32'(score),     32'(vecs[j].score));
      chk($sformatf("v%0d_combo", j), 32'(combo),     32'(vecs[j].combo));
      chk($sformatf("v%0d_hp", j),    32'(hp),        therm(vecs[j].hp));
      chk($sformatf("v%0d_judge", j), 32'(judge),     32'(vecs[j].judge));
      chk($sformatf("v%0d_vld", j),   32'(judge_vld), 32'(vecs[j].vld));
      chk($sformatf("v%0d_state", j), 32'(state),     32'h1);
    end
    pulse = '0;

    run_until_over(400, ok);
    chk("game1_over_reached", 32'(ok), 32'h1);
    chk("game1_over_state", 32'(state), 32'h2);
    chk("game1_over_hp",    32'(hp),    32'h0);
    chk("game1_over_score", 32'(score), 32'd45);
    chk("game1_high",       32'(high),  32'd45);

    start = 1'b0; pulse = '1;
    step();
    pulse = '0;
    chk("over_to_idle_state", 32'(state), 32'h0);
    chk("idle_press_ignored", 32'(score), 32'd45);

    start = 1'b1;
    step();
    step();
    chk("replay_state", 32'(state), 32'h1);
    chk("replay_score", 32'(score), 32'h0);
    chk("replay_combo", 32'(combo), 32'h0);
    chk("replay_map",   32'(map),   32'h0);
    chk("replay_hp",    32'(hp),    32'h3FF);

    run_until_over(400, ok);
    chk("game2_over_reached", 32'(ok), 32'h1);
    chk("game2_over_state", 32'(state), 32'h2);
    chk("game2_high_kept",  32'(high),  32'd45);

    start = 1'b0;
    step();
    start = 1'b1;
    step();
    step();
    chk("game3_state", 32'(state), 32'h1);
    rnd = 8'h81;
    for (int i = 0; i < 6; i++) step();
    rnd = 8'h00;
    rst = 1'b1;
    step();
    chk_idle_reset("midplay_reset");
    rst = 1'b0; start = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
